// File: rtl/gpio_cmd_regfile.sv
`default_nettype none
// ============================================================================
// Module   : gpio_cmd_regfile
// Brief    : GPIO command decoder with control register bank and log capture RAM.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_cmd_regfile #(
   parameter int NB_GPIOS        = 32,
   parameter int NB_REGS         = 8,
   parameter int NB_REG          = 16,
   parameter int NB_DATA_RAM_LOG = 24,
   parameter int NB_ADDR_RAM_LOG = 10
) (
   input  logic                       clk100,
   input  logic                       in_reset,
   input  logic [NB_GPIOS-1:0]        i_gpo,
   output logic [NB_GPIOS-1:0]        o_gpi,
   input  logic [NB_DATA_RAM_LOG-1:0] i_log_data,
   input  logic                       i_log_valid,
   output logic [NB_REGS*NB_REG-1:0]  o_regs,
   output logic                       o_log_busy,
   output logic                       o_log_full
);

   localparam int         c_DEPTH   = 1 << NB_ADDR_RAM_LOG;
   localparam int         c_NB_PTR  = NB_ADDR_RAM_LOG + 1;
   localparam int         c_NB_RSP  = 29;

   localparam logic [2:0] c_OP_WR_REG    = 3'd1;
   localparam logic [2:0] c_OP_RD_REG    = 3'd2;
   localparam logic [2:0] c_OP_LOG_START = 3'd3;
   localparam logic [2:0] c_OP_LOG_STOP  = 3'd4;
   localparam logic [2:0] c_OP_LOG_RD    = 3'd5;
   localparam logic [2:0] c_OP_LOG_CNT   = 3'd6;

   localparam logic [1:0] c_SEL_HOLD = 2'd0;
   localparam logic [1:0] c_SEL_REG  = 2'd1;
   localparam logic [1:0] c_SEL_RAM  = 2'd2;
   localparam logic [1:0] c_SEL_CNT  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_FULL    = 2'd2
   } state_t;

   logic [NB_GPIOS-1:0]        r_g1;
   logic                       r_g2_stb;
   logic                       w_accept;
   logic [2:0]                 w_op;
   logic [6:0]                 w_addr;
   logic [15:0]                w_data;
   logic                       w_unused_g1;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [c_NB_PTR-1:0]        r_ptr;
   logic [c_NB_PTR-1:0]        w_ptr_nxt;
   logic                       w_we;

   logic [NB_REG-1:0]          r_regs [NB_REGS];
   logic [NB_REG-1:0]          w_reg_rd;

   logic [NB_DATA_RAM_LOG-1:0] r_mem [c_DEPTH];
   logic [NB_ADDR_RAM_LOG-1:0] r_rd_addr;
   logic [6:0]                 r_reg_addr;
   logic [1:0]                 r_sel;
   logic                       r_pend;
   logic                       r_ack;
   logic [c_NB_RSP-1:0]        r_data;

   // Strobe edge detect on the registered GPO word
   always_ff @(posedge clk100) begin
      if (in_reset) begin
         r_g1     <= '0;
         r_g2_stb <= 1'b0;
      end else begin
         r_g1     <= i_gpo;
         r_g2_stb <= r_g1[23];
      end
   end

   assign w_accept    = r_g1[23] & ~r_g2_stb;
   assign w_op        = r_g1[31:29];
   assign w_addr      = r_g1[22:16];
   assign w_data      = r_g1[15:0];
   assign w_unused_g1 = ^r_g1;

   always_ff @(posedge clk100) begin
      if (in_reset) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   // Commands take priority over a sample arriving in the same cycle
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_we        = 1'b0;
      if (w_accept && w_op == c_OP_LOG_START) begin
         w_state_nxt = ST_CAPTURE;
         w_ptr_nxt   = '0;
      end else if (w_accept && w_op == c_OP_LOG_STOP) begin
         w_state_nxt = ST_IDLE;
      end else if (r_state == ST_CAPTURE && i_log_valid) begin
         w_we      = ~in_reset;
         w_ptr_nxt = r_ptr + {{NB_ADDR_RAM_LOG{1'b0}}, 1'b1};
         if (&r_ptr[NB_ADDR_RAM_LOG-1:0]) begin
            w_state_nxt = ST_FULL;
         end
      end
   end

   always_ff @(posedge clk100) begin
      if (w_we) begin
         r_mem[r_ptr[NB_ADDR_RAM_LOG-1:0]] <= i_log_data;
      end
   end

   // Out-of-range addresses simply match no register
   always_ff @(posedge clk100) begin
      if (in_reset) begin
         for (int r = 0; r < NB_REGS; r++) begin
            r_regs[r] <= '0;
         end
      end else if (w_accept && w_op == c_OP_WR_REG) begin
         for (int r = 0; r < NB_REGS; r++) begin
            if (w_addr == 7'(r)) begin
               r_regs[r] <= w_data[NB_REG-1:0];
            end
         end
      end
   end

   always_comb begin
      w_reg_rd = '0;
      for (int r = 0; r < NB_REGS; r++) begin
         if (r_reg_addr == 7'(r)) begin
            w_reg_rd = r_regs[r];
         end
      end
   end

   always_ff @(posedge clk100) begin
      if (in_reset) begin
         r_pend     <= 1'b0;
         r_sel      <= c_SEL_HOLD;
         r_rd_addr  <= '0;
         r_reg_addr <= '0;
         r_ack      <= 1'b0;
         r_data     <= '0;
      end else begin
         r_pend     <= w_accept;
         r_rd_addr  <= r_g1[NB_ADDR_RAM_LOG-1:0];
         r_reg_addr <= w_addr;
         r_sel      <= c_SEL_HOLD;
         if (w_accept) begin
            case (w_op)
               c_OP_RD_REG:  r_sel <= c_SEL_REG;
               c_OP_LOG_RD:  r_sel <= c_SEL_RAM;
               c_OP_LOG_CNT: r_sel <= c_SEL_CNT;
               default:      r_sel <= c_SEL_HOLD;
            endcase
         end
         if (r_pend) begin
            r_ack <= ~r_ack;
         end
         case (r_sel)
            c_SEL_REG: r_data <= c_NB_RSP'(w_reg_rd);
            c_SEL_RAM: r_data <= c_NB_RSP'(r_mem[r_rd_addr]);
            c_SEL_CNT: r_data <= c_NB_RSP'(r_ptr);
            default:   r_data <= r_data;
         endcase
      end
   end

   generate
      for (genvar r = 0; r < NB_REGS; r++) begin : g_regs
         assign o_regs[r*NB_REG +: NB_REG] = r_regs[r];
      end
   endgenerate

   assign o_log_busy = (r_state == ST_CAPTURE);
   assign o_log_full = (r_state == ST_FULL);

   always_comb begin
      o_gpi       = '0;
      o_gpi[31:0] = {o_log_busy, o_log_full, r_ack, r_data};
   end

endmodule
`default_nettype wire

// File: tb/tb_gpio_cmd_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_cmd_regfile
// Brief    : Self-checking bench for gpio_cmd_regfile with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_cmd_regfile;

   localparam int NB_GPIOS = 32;
   localparam int NB_REGS  = 8;
   localparam int NB_REG   = 16;
   localparam int NB_DATA  = 24;
   localparam int NB_ADDR  = 10;
   localparam int DEPTH    = 1 << NB_ADDR;

   logic                      clk100 = 1'b0;
   logic                      in_reset = 1'b1;
   logic [NB_GPIOS-1:0]       i_gpo = '0;
   logic [NB_GPIOS-1:0]       o_gpi;
   logic [NB_DATA-1:0]        i_log_data = '0;
   logic                      i_log_valid = 1'b0;
   logic [NB_REGS*NB_REG-1:0] o_regs;
   logic                      o_log_busy;
   logic                      o_log_full;

   always #5 clk100 = ~clk100;

   gpio_cmd_regfile #(
      .NB_GPIOS(NB_GPIOS), .NB_REGS(NB_REGS), .NB_REG(NB_REG),
      .NB_DATA_RAM_LOG(NB_DATA), .NB_ADDR_RAM_LOG(NB_ADDR)
   ) dut (
      .clk100(clk100), .in_reset(in_reset), .i_gpo(i_gpo), .o_gpi(o_gpi),
      .i_log_data(i_log_data), .i_log_valid(i_log_valid), .o_regs(o_regs),
      .o_log_busy(o_log_busy), .o_log_full(o_log_full)
   );

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;
   bit rnd    = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int          m_regs [NB_REGS];
   int          m_mem  [DEPTH];
   bit          m_wr   [DEPTH];
   int          m_ptr;
   int          m_state;            // 0 idle, 1 capture, 2 full
   bit          m_ack;
   int          m_data;
   bit          m_known;
   logic [31:0] m_g1;
   bit          m_g2stb;
   bit          m_pend;
   logic [31:0] m_pcmd;

   task automatic model_step();
      int  op, addr, a;
      bit  fsm_cmd;
      if (in_reset) begin
         foreach (m_regs[r]) m_regs[r] = 0;
         m_ptr = 0; m_state = 0; m_ack = 0; m_data = 0; m_known = 1;
         m_g1 = '0; m_g2stb = 0; m_pend = 0; m_pcmd = '0;
         return;
      end
      if (m_pend) begin
         m_ack = !m_ack;
         addr = int'(m_pcmd[22:16]);
         case (int'(m_pcmd[31:29]))
            2: begin m_data = (addr < NB_REGS) ? m_regs[addr] : 0; m_known = 1; end
            5: begin a = int'(m_pcmd[NB_ADDR-1:0]); m_data = m_mem[a]; m_known = m_wr[a]; end
            6: begin m_data = m_ptr; m_known = 1; end
            default: ;
         endcase
      end
      m_pend  = m_g1[23] && !m_g2stb;
      fsm_cmd = 0;
      if (m_pend) begin
         op   = int'(m_g1[31:29]);
         addr = int'(m_g1[22:16]);
         m_pcmd = m_g1;
         if (op == 1 && addr < NB_REGS) m_regs[addr] = int'(m_g1[NB_REG-1:0]);
         if (op == 3) begin m_ptr = 0; m_state = 1; fsm_cmd = 1; end
         if (op == 4) begin m_state = 0; fsm_cmd = 1; end
      end
      if (!fsm_cmd && m_state == 1 && i_log_valid) begin
         m_mem[m_ptr] = int'(i_log_data);
         m_wr[m_ptr]  = 1;
         m_ptr++;
         if (m_ptr == DEPTH) m_state = 2;
      end
      m_g2stb = m_g1[23];
      m_g1    = i_gpo;
   endtask

   initial forever begin
      @(posedge clk100);
      model_step();
   end

   // One compare process, every cycle once the model is reset
   initial forever begin
      logic [NB_REGS*NB_REG-1:0] er;
      logic [31:0]               eg;
      @(negedge clk100);
      if (chk_en) begin
         for (int r = 0; r < NB_REGS; r++) er[r*NB_REG +: NB_REG] = m_regs[r][NB_REG-1:0];
         eg = {m_state == 1, m_state == 2, m_ack, m_data[28:0]};
         check("regs", 128'(o_regs), 128'(er));
         check("busy", 128'(o_log_busy), 128'(m_state == 1));
         check("full", 128'(o_log_full), 128'(m_state == 2));
         if (m_known) check("gpi", 128'(o_gpi), 128'(eg));
         else         check("gpi_hdr", 128'(o_gpi[31:29]), 128'(eg[31:29]));
      end
   end

   // ---------------- stimulus ----------------
   bit exp_ack = 1'b0;

   task automatic tick();
      @(posedge clk100); #1;
      if (rnd) begin
         i_log_valid = 1'($urandom_range(0, 1));
         i_log_data  = NB_DATA'($urandom);
      end
   endtask

   function automatic logic [31:0] mk(input int op, input int addr, input int data);
      return {3'(op), 5'b0, 1'b1, 7'(addr), 16'(data)};
   endfunction

   task automatic issue(input logic [31:0] w, input int hold);
      i_gpo     = w;
      i_gpo[23] = 1'b1;
      repeat (hold) tick();
      i_gpo[23] = 1'b0;
      tick();
      exp_ack = !exp_ack;
   endtask

   task automatic cmd(input int op, input int addr, input int data);
      issue(mk(op, addr, data), 1);
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk100); #1;
      chk_en = 1'b1;
      repeat (2) tick();
      in_reset = 1'b0;
      check("rst_regs", 128'(o_regs), 128'(0));
      check("rst_gpi", 128'(o_gpi), 128'(0));
      check("rst_busy", 128'(o_log_busy), 128'(0));
      check("rst_full", 128'(o_log_full), 128'(0));

      issue(mk(1, 3, 'hBEEF), 1);
      check("wr_edge1", 128'(o_regs[3*NB_REG +: NB_REG]), 128'(16'hBEEF));
      tick();
      check("wr_ack", 128'(o_gpi[29]), 128'(exp_ack));
      cmd(2, 3, 0);
      check("rd3_data", 128'(o_gpi[28:0]), 128'(29'hBEEF));
      check("rd3_ack", 128'(o_gpi[29]), 128'(exp_ack));
      cmd(0, 3, 'h5555);
      check("nop_data", 128'(o_gpi[28:0]), 128'(29'hBEEF));
      check("nop_ack", 128'(o_gpi[29]), 128'(exp_ack));
      cmd(2, 100, 0);
      check("rd100_data", 128'(o_gpi[28:0]), 128'(0));
      check("rd100_ack", 128'(o_gpi[29]), 128'(exp_ack));
      issue(mk(1, 5, 'h1234), 10);
      repeat (3) tick();
      check("hold_ack", 128'(o_gpi[29]), 128'(exp_ack));
      check("hold_reg5", 128'(o_regs[5*NB_REG +: NB_REG]), 128'(16'h1234));

      // Fill the log completely with a counter
      issue(mk(3, 0, 0), 1);
      check("start_busy", 128'(o_log_busy), 128'(1));
      for (int i = 0; i < 1030; i++) begin
         i_log_data  = NB_DATA'(i);
         i_log_valid = 1'b1;
         tick();
         if (i == 1022) check("full_pre", 128'(o_log_full), 128'(0));
         if (i == 1023) check("full_rise", 128'(o_log_full), 128'(1));
      end
      i_log_valid = 1'b0;
      cmd(6, 0, 0);
      check("fill_cnt", 128'(o_gpi[28:0]), 128'(1024));
      check("fill_hdr", 128'(o_gpi[31:30]), 128'(2'b01));
      cmd(5, 0, 'h3FF);
      check("fill_rd3ff", 128'(o_gpi[28:0]), 128'(1023));
      cmd(5, 0, 5);
      check("fill_rd5", 128'(o_gpi[28:0]), 128'(5));

      // Sparse capture then stop
      issue(mk(3, 0, 0), 1);
      for (int i = 0; i < 100; i++) begin
         i_log_data  = NB_DATA'(1000 + i);
         i_log_valid = (i % 2 == 0);
         tick();
      end
      i_log_valid = 1'b0;
      cmd(4, 0, 0);
      check("stop_busy", 128'(o_log_busy), 128'(0));
      cmd(6, 0, 0);
      check("sparse_cnt", 128'(o_gpi[28:0]), 128'(50));
      for (int k = 0; k < 50; k++) begin
         cmd(5, 0, k);
         check("sparse_rd", 128'(o_gpi[28:0]), 128'(1000 + 2 * k));
      end

      // Reset during capture at pointer 20
      issue(mk(3, 0, 0), 1);
      for (int k = 0; k < 20; k++) begin
         i_log_data  = NB_DATA'(5000 + k);
         i_log_valid = 1'b1;
         tick();
      end
      i_log_data = NB_DATA'(9999);
      in_reset   = 1'b1;
      tick();
      in_reset    = 1'b0;
      i_log_valid = 1'b0;
      exp_ack     = 1'b0;
      check("mrst_regs", 128'(o_regs), 128'(0));
      check("mrst_gpi", 128'(o_gpi), 128'(0));
      cmd(6, 0, 0);
      check("mrst_cnt", 128'(o_gpi[28:0]), 128'(0));
      cmd(5, 0, 10);
      check("mrst_rd10", 128'(o_gpi[28:0]), 128'(5010));
      cmd(5, 0, 20);
      check("mrst_rd20", 128'(o_gpi[28:0]), 128'(1040));

      // Randomized commands against the model
      rnd = 1'b1;
      for (int n = 0; n < 400; n++) begin
         logic [31:0] w;
         w = $urandom;
         w[22:16] = 7'($urandom_range(0, 11));
         issue(w, ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 5)) : 1);
         repeat ($urandom_range(0, 2)) tick();
      end
      rnd = 1'b0;
      i_log_valid = 1'b0;
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
